// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit.
// A registered state machine walks each instruction through fetch, decode,
// execute, memory and write-back. Datapath controls are decoded from the
// current state. mem_ready only gates write-enables and transitions.
// A wait counter bounds every memory access. An expired wait or an unknown
// opcode sends the machine to TRAP, and a 1-bit cause register records which
// of the two happened.
module multicycle_control #(
    parameter int HALT_ON_ILLEGAL = 0,
    parameter int ENABLE_ORI      = 1,
    parameter int MEM_TIMEOUT     = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t          state_r;
    state_t          next_state_s;
    logic [CW-1:0]   wait_cnt_r;
    logic            trap_cause_r;   // 1 = memory timeout, 0 = illegal opcode
    logic            mem_state_s;
    logic            timeout_s;
    logic            ori_legal_s;

    assign state       = state_r;
    assign ori_legal_s = (ENABLE_ORI != 0);
    assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    // mem_ready in the expiry cycle wins: the access completes instead.
    assign timeout_s   = (MEM_TIMEOUT != 0) && mem_state_s && !mem_ready &&
                         (wait_cnt_r == CW'(MEM_TIMEOUT));

    // State register: asynchronous reset to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait counter: counts only while stalling in a memory state, zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {CW{1'b0}};
        end else if (mem_state_s && (next_state_s == state_r) && !mem_ready) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= {CW{1'b0}};
        end
    end

    // Trap cause: captured on the transition into TRAP, held while there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_cause_r <= 1'b0;
        end else if ((state_r != S_TRAP) && (next_state_s == S_TRAP)) begin
            trap_cause_r <= timeout_s;
        end else begin
            trap_cause_r <= trap_cause_r;
        end
    end

    // Next-state and control decode from the registered state.
    always_comb begin
        next_state_s = S_FETCH;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemToReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = ALU_ADD;
        PCSource     = 2'b00;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        mem_err      = 1'b0;
        case (state_r)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // Reset masks the fetch write-enables so none fire during reset.
                if (mem_ready && !reset) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end else begin
                    IRWrite = 1'b0;
                    PCWrite = 1'b0;
                end
                if (mem_ready) begin
                    next_state_s = S_DECODE;
                end else if (timeout_s) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state_s = S_MEMADR;
                    OP_RTYPE:     next_state_s = S_EXEC;
                    OP_BEQ:       next_state_s = S_BRANCH;
                    OP_ADDI:      next_state_s = S_IMMEX;
                    OP_ORI:       next_state_s = ori_legal_s ? S_IMMEX : S_TRAP;
                    OP_J:         next_state_s = S_JUMP;
                    default:      next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                next_state_s = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    next_state_s = S_MEMWB;
                end else if (timeout_s) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done   = 1'b1;
                    next_state_s = S_FETCH;
                end else if (timeout_s) begin
                    next_state_s = S_TRAP;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALU_FUNCT;
                next_state_s = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_IMMEX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOp        = (ori_legal_s && (opcode == OP_ORI)) ? ALU_OR : ALU_ADD;
                next_state_s = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                illegal_op   = !trap_cause_r;
                mem_err      = trap_cause_r;
                next_state_s = (HALT_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Three instances share clock, opcode
// and mem_ready: the default configuration, one with ori disabled, and one
// that halts in TRAP. Each has its own reset. Every instance's controls are
// packed into a 20-bit vector so whole control words can be compared at once:
// [0]PCWrite [1]PCWriteCond [2]IorD [3]MemRead [4]MemWrite [5]IRWrite
// [6]MemToReg [7]RegDst [8]RegWrite [9]ALUSrcA [11:10]ALUSrcB [14:12]ALUOp
// [16:15]PCSource [17]instr_done [18]illegal_op [19]mem_err
module tb_multicycle_control;

    localparam int PCW = 0, PCWC = 1, IORD = 2, MRD = 3, MWR = 4, IRW = 5;
    localparam int M2R = 6, RDST = 7, RWR = 8, SRCA = 9, DONE = 17;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        mem_ready;
    logic [5:0]  opcode;
    logic [19:0] ca, cb, cc;
    logic [3:0]  sa, sb, sc;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(.HALT_ON_ILLEGAL(0), .ENABLE_ORI(1), .MEM_TIMEOUT(15)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(ca[0]), .PCWriteCond(ca[1]), .IorD(ca[2]), .MemRead(ca[3]),
        .MemWrite(ca[4]), .IRWrite(ca[5]), .MemToReg(ca[6]), .RegDst(ca[7]),
        .RegWrite(ca[8]), .ALUSrcA(ca[9]), .ALUSrcB(ca[11:10]), .ALUOp(ca[14:12]),
        .PCSource(ca[16:15]), .instr_done(ca[17]), .illegal_op(ca[18]),
        .mem_err(ca[19]), .state(sa)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(0), .ENABLE_ORI(0), .MEM_TIMEOUT(15)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(cb[0]), .PCWriteCond(cb[1]), .IorD(cb[2]), .MemRead(cb[3]),
        .MemWrite(cb[4]), .IRWrite(cb[5]), .MemToReg(cb[6]), .RegDst(cb[7]),
        .RegWrite(cb[8]), .ALUSrcA(cb[9]), .ALUSrcB(cb[11:10]), .ALUOp(cb[14:12]),
        .PCSource(cb[16:15]), .instr_done(cb[17]), .illegal_op(cb[18]),
        .mem_err(cb[19]), .state(sb)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1), .ENABLE_ORI(1), .MEM_TIMEOUT(15)) dut_c (
        .clk(clk), .reset(rst_c), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(cc[0]), .PCWriteCond(cc[1]), .IorD(cc[2]), .MemRead(cc[3]),
        .MemWrite(cc[4]), .IRWrite(cc[5]), .MemToReg(cc[6]), .RegDst(cc[7]),
        .RegWrite(cc[8]), .ALUSrcA(cc[9]), .ALUSrcB(cc[11:10]), .ALUOp(cc[14:12]),
        .PCSource(cc[16:15]), .instr_done(cc[17]), .illegal_op(cc[18]),
        .mem_err(cc[19]), .state(sc)
    );

    // Count one comparison and report it if the value differs.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        mem_ready = 1'b1; opcode = 6'b000000;

        // Reset: MemRead and ALUSrcB=01 only, fetch writes masked.
        cyc;
        check_val("rst_state", {28'd0, sa}, 32'd0);
        check_val("rst_ctl", {12'd0, ca}, 32'h00408);
        rst_a = 1'b0; #1;

        // R-type: 0,1,6,7,0
        check_val("r_fetch_irw", {31'd0, ca[IRW]}, 32'd1);
        check_val("r_fetch_pcw", {31'd0, ca[PCW]}, 32'd1);
        cyc; check_val("r_dec", {28'd0, sa}, 32'd1);
        check_val("r_dec_srcb", {30'd0, ca[11:10]}, 32'd3);
        check_val("r_dec_done", {31'd0, ca[DONE]}, 32'd0);
        cyc; check_val("r_exec", {28'd0, sa}, 32'd6);
        check_val("r_exec_aluop", {29'd0, ca[14:12]}, 32'd2);
        check_val("r_exec_done", {31'd0, ca[DONE]}, 32'd0);
        cyc; check_val("r_wb", {28'd0, sa}, 32'd7);
        check_val("r_wb_ctl", {12'd0, ca}, 32'h20180);
        cyc; check_val("r_back", {28'd0, sa}, 32'd0);
        check_val("r_back_done", {31'd0, ca[DONE]}, 32'd0);

        // lw with three stall cycles in MEMRD: 8 cycles total
        opcode = 6'b100011;
        cyc; check_val("lw_dec", {28'd0, sa}, 32'd1);
        cyc; check_val("lw_adr", {28'd0, sa}, 32'd2);
        check_val("lw_adr_srcb", {30'd0, ca[11:10]}, 32'd2);
        check_val("lw_adr_srca", {31'd0, ca[SRCA]}, 32'd1);
        mem_ready = 1'b0;
        cyc; check_val("lw_rd", {28'd0, sa}, 32'd3);
        check_val("lw_rd_ctl", {12'd0, ca}, 32'h0000C);
        repeat (2) cyc;
        check_val("lw_rd_stall", {28'd0, sa}, 32'd3);
        cyc; check_val("lw_rd_last", {28'd0, sa}, 32'd3);
        mem_ready = 1'b1; #1;
        check_val("lw_rd_m2r", {31'd0, ca[M2R]}, 32'd0);
        cyc; check_val("lw_wb", {28'd0, sa}, 32'd4);
        check_val("lw_wb_ctl", {12'd0, ca}, 32'h20140);
        cyc; check_val("lw_back", {28'd0, sa}, 32'd0);
        check_val("lw_back_rwr", {31'd0, ca[RWR]}, 32'd0);

        // sw with no wait: 0,1,2,5,0
        opcode = 6'b101011;
        cyc; cyc; cyc; check_val("sw_wr", {28'd0, sa}, 32'd5);
        check_val("sw_wr_ctl", {12'd0, ca}, 32'h20014);
        cyc; check_val("sw_back", {28'd0, sa}, 32'd0);

        // ori: OR in IMMEX, write-back with RegDst=0
        opcode = 6'b001101;
        cyc; cyc; check_val("ori_ex", {28'd0, sa}, 32'd9);
        check_val("ori_aluop", {29'd0, ca[14:12]}, 32'd3);
        check_val("ori_srcb", {30'd0, ca[11:10]}, 32'd2);
        cyc; check_val("ori_wb", {28'd0, sa}, 32'd10);
        check_val("ori_wb_ctl", {12'd0, ca}, 32'h20100);
        cyc; check_val("ori_back", {28'd0, sa}, 32'd0);

        // addi: ADD in IMMEX
        opcode = 6'b001000;
        cyc; cyc; check_val("addi_ex", {28'd0, sa}, 32'd9);
        check_val("addi_aluop", {29'd0, ca[14:12]}, 32'd0);
        cyc; cyc; check_val("addi_back", {28'd0, sa}, 32'd0);

        // beq: 3 cycles, PCWriteCond/SUB/ALUOut, never PCWrite
        opcode = 6'b000100;
        cyc; cyc; check_val("beq_br", {28'd0, sa}, 32'd8);
        check_val("beq_ctl", {12'd0, ca}, 32'h29202);
        check_val("beq_pcw", {31'd0, ca[PCW]}, 32'd0);
        cyc; check_val("beq_back", {28'd0, sa}, 32'd0);

        // j: 3 cycles, PCWrite with jump target
        opcode = 6'b000010;
        cyc; cyc; check_val("j_jump", {28'd0, sa}, 32'd11);
        check_val("j_ctl", {12'd0, ca}, 32'h30001);
        cyc; check_val("j_back", {28'd0, sa}, 32'd0);

        // illegal opcode, one-cycle trap
        opcode = 6'b111111;
        cyc; cyc; check_val("ill_trap", {28'd0, sa}, 32'd12);
        check_val("ill_ctl", {12'd0, ca}, 32'h40000);
        cyc; check_val("ill_back", {28'd0, sa}, 32'd0);

        // FETCH timeout: 16 cycles in FETCH, then TRAP with mem_err
        opcode = 6'b000000;
        mem_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check_val("to_wait", {28'd0, sa}, 32'd0);
            cyc;
        end
        check_val("to_trap", {28'd0, sa}, 32'd12);
        check_val("to_ctl", {12'd0, ca}, 32'h80000);
        cyc; check_val("to_back", {28'd0, sa}, 32'd0);

        // mem_ready on the 16th cycle beats the timeout
        for (int i = 1; i <= 15; i++) begin
            check_val("nto_wait", {28'd0, sa}, 32'd0);
            cyc;
        end
        mem_ready = 1'b1; #1;
        check_val("nto_irw", {31'd0, ca[IRW]}, 32'd1);
        cyc; check_val("nto_dec", {28'd0, sa}, 32'd1);
        cyc; cyc; cyc; check_val("nto_back", {28'd0, sa}, 32'd0);

        // reset mid-sw while waiting in MEMWR aborts at once
        opcode = 6'b101011;
        cyc; cyc; mem_ready = 1'b0;
        cyc; check_val("ab_wr", {28'd0, sa}, 32'd5);
        check_val("ab_mwr", {31'd0, ca[MWR]}, 32'd1);
        check_val("ab_done", {31'd0, ca[DONE]}, 32'd0);
        #1; rst_a = 1'b1; #1;
        check_val("ab_state", {28'd0, sa}, 32'd0);
        check_val("ab_ctl", {12'd0, ca}, 32'h00408);
        mem_ready = 1'b1; #1;
        check_val("ab_ctl_rdy", {12'd0, ca}, 32'h00408);

        // ENABLE_ORI=0: ori traps for one cycle with illegal_op
        opcode = 6'b001101;
        cyc; rst_b = 1'b0; #1;
        check_val("b_fetch", {28'd0, sb}, 32'd0);
        cyc; check_val("b_dec", {28'd0, sb}, 32'd1);
        cyc; check_val("b_trap", {28'd0, sb}, 32'd12);
        check_val("b_trap_ctl", {12'd0, cb}, 32'h40000);
        cyc; check_val("b_back", {28'd0, sb}, 32'd0);

        // HALT_ON_ILLEGAL=1: TRAP holds until an asynchronous reset
        opcode = 6'b111111;
        cyc; rst_c = 1'b0;
        cyc; check_val("c_dec", {28'd0, sc}, 32'd1);
        cyc;
        for (int i = 0; i < 5; i++) begin
            check_val("c_hold", {28'd0, sc}, 32'd12);
            check_val("c_ill", {12'd0, cc}, 32'h40000);
            cyc;
        end
        #1; rst_c = 1'b1; #1;
        check_val("c_async_rst", {28'd0, sc}, 32'd0);
        check_val("c_async_ctl", {12'd0, cc}, 32'h00408);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
